// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - byte/half/word load-store unit with read-modify-write on a word-only memory
// Optional feature macro: LSU_MISALIGN_TRAP_EN (report misaligned accesses instead of aligning them down)
module lsu_mem_master (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_UNSIGNED,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        MEM_WE,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_WD,
    input  logic [31:0] MEM_RD
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] eff_addr;

    // Size 2'b11 behaves as a word everywhere, so only size[1] is tested for "word".
    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] r;
        r = a;
        if (sz == 2'b01) r[0] = 1'b0;
        else if (sz[1]) r[1:0] = 2'b00;
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   return {{24{b[7] & ~uns}}, b};
            2'b01:   return {{16{h[15] & ~uns}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        case (sz)
            2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q, err_d;

    function automatic logic is_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
    endfunction
`endif

    assign eff_addr = align_addr(REQ_ADDR, REQ_SIZE);

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        mem_we_d    = mem_we_q;
        mem_a_d     = mem_a_q;
        mem_wd_d    = mem_wd_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    we_d        = REQ_WE;
                    size_d      = REQ_SIZE;
                    uns_d       = REQ_UNSIGNED;
                    addr_d      = eff_addr;
                    wdata_d     = REQ_WDATA;
                    mem_a_d     = {eff_addr[31:2], 2'b00};
                    rdata_d     = 32'd0;
                    req_ready_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    err_d       = 1'b0;
`endif
                    if (REQ_WE && REQ_SIZE[1]) begin
                        mem_wd_d = REQ_WDATA;
                        mem_we_d = 1'b1;
                        state_d  = S_WRITE;
                    end else begin
                        state_d  = S_READ;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(REQ_ADDR, REQ_SIZE)) begin
                        err_d       = 1'b1;
                        mem_we_d    = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
`endif
                end
            end
            S_READ: begin
                if (we_q) begin
                    mem_wd_d = store_merge(MEM_RD, wdata_q, size_q, addr_q[1:0]);
                    mem_we_d = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    rdata_d     = load_extract(MEM_RD, size_q, addr_q[1:0], uns_q);
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_WRITE: begin
                mem_we_d    = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_a_q     <= 32'd0;
            mem_wd_q    <= 32'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            mem_we_q    <= mem_we_d;
            mem_a_q     <= mem_a_d;
            mem_wd_q    <= mem_wd_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q       <= err_d;
`endif
        end
    end

    assign REQ_READY = req_ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rdata_q;
    // A reset asserted during WRITE must suppress the strobe in that same cycle.
    assign MEM_WE    = mem_we_q & RST_N;
    assign MEM_A     = mem_a_q;
    assign MEM_WD    = mem_wd_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign RSP_ERR   = err_q;
`else
    assign RSP_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - randomized self-checking bench for lsu_mem_master against a behavioural model
module tb_lsu_mem_master;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID, REQ_READY, REQ_WE, REQ_UNSIGNED;
    logic [1:0]  REQ_SIZE;
    logic [31:0] REQ_ADDR, REQ_WDATA;
    logic        RSP_VALID, RSP_READY, RSP_ERR;
    logic [31:0] RSP_RDATA;
    logic        MEM_WE;
    logic [31:0] MEM_A, MEM_WD, MEM_RD;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    int total = 0;
    int bad   = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    lsu_mem_master dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .MEM_WE(MEM_WE),
        .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
    );

    always #5 CLK = ~CLK;

    assign MEM_RD = mem[MEM_A[9:2]];
    always @(posedge CLK) if (MEM_WE) mem[MEM_A[9:2]] <= MEM_WD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Expected outcome of one request, from byte-lane arithmetic on a word array.
    task automatic model_txn(input logic we, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] e_rd, output logic e_err, output int e_lat,
                             output int e_wes, output logic [31:0] e_wa, output logic [31:0] e_wd);
        int unsigned nb, off, ea, wi;
        longint unsigned mask, w;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e_rd = 0; e_err = 0; e_wes = 0; e_wa = 0; e_wd = 0; e_lat = 2;
        if (TRAP && (a % nb) != 0) begin
            e_err = 1'b1;
            e_lat = 1;
            return;
        end
        ea   = a - (a % nb);
        off  = ea % 4;
        wi   = ea / 4;
        mask = (64'd1 << (8 * nb)) - 1;
        w    = 64'(ref_mem[wi]);
        if (!we) begin
            e_rd = 32'((w >> (8 * off)) & mask);
            if (!u && nb < 4 && e_rd[8 * nb - 1]) e_rd = e_rd | ~32'(mask);
        end else begin
            e_lat = (nb == 4) ? 2 : 3;
            e_wes = 1;
            e_wa  = ea - off;
            e_wd  = 32'((w & ~(mask << (8 * off))) | ((64'(wd) & mask) << (8 * off)));
            ref_mem[wi] = e_wd;
        end
    endtask

    task automatic do_txn(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int stall, input bit poke, output logic [31:0] got_rd);
        logic [31:0] e_rd, e_wa, e_wd, wa, wwd;
        logic e_err;
        int e_lat, e_wes, cyc, wecnt, wecyc;
        model_txn(we, sz, u, a, wd, e_rd, e_err, e_lat, e_wes, e_wa, e_wd);
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = u;
        REQ_ADDR = a; REQ_WDATA = wd; RSP_READY = 1'b0;
        cyc = 0;
        while (!REQ_READY && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("req_ready_before_accept", 32'(REQ_READY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0; REQ_ADDR = $urandom; REQ_WDATA = $urandom; REQ_WE = 1'($urandom);
        cyc = 1; wecnt = 0; wecyc = 0; wa = 0; wwd = 0;
        while (cyc < 12) begin
            if (MEM_WE) begin
                wecnt++; wecyc = cyc; wa = MEM_A; wwd = MEM_WD;
            end
            if (RSP_VALID) break;
            @(negedge CLK);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(e_lat));
        chk("rsp_rdata", RSP_RDATA, e_rd);
        chk("rsp_err", 32'(RSP_ERR), 32'(e_err));
        chk("mem_we_pulses", 32'(wecnt), 32'(e_wes));
        if (e_wes == 1) begin
            chk("mem_we_cycle", 32'(wecyc), 32'(e_lat - 1));
            chk("mem_a_at_write", wa, e_wa);
            chk("mem_wd_at_write", wwd, e_wd);
        end
        got_rd = RSP_RDATA;
        for (int i = 0; i < stall; i++) begin
            if (poke && i == 1) begin
                REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'd2;
                REQ_ADDR = a & 32'h3FC; REQ_WDATA = 32'h5A5A5A5A;
            end
            @(negedge CLK);
            REQ_VALID = 1'b0;
            chk("stall_rsp_valid", 32'(RSP_VALID), 32'd1);
            chk("stall_rdata", RSP_RDATA, e_rd);
            chk("stall_err", 32'(RSP_ERR), 32'(e_err));
            chk("stall_req_ready", 32'(REQ_READY), 32'd0);
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        chk("rsp_valid_after_ack", 32'(RSP_VALID), 32'd0);
        chk("req_ready_after_ack", 32'(REQ_READY), 32'd1);
        chk("mem_word", mem[a[9:2]], ref_mem[a[9:2]]);
    endtask

    initial begin
        logic [31:0] rd;
        RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'd0; REQ_UNSIGNED = 1'b0;
        REQ_ADDR = 32'd0; REQ_WDATA = 32'd0; RSP_READY = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16] = 32'h8899AABB; ref_mem[16] = 32'h8899AABB;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", 32'(REQ_READY), 32'd1);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_rsp_rdata", RSP_RDATA, 32'd0);
        chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
        chk("rst_mem_we", 32'(MEM_WE), 32'd0);
        chk("rst_mem_a", MEM_A, 32'd0);
        chk("rst_mem_wd", MEM_WD, 32'd0);
        RST_N = 1'b1;

        do_txn(1'b0, 2'd0, 1'b0, 32'h41, 32'd0, 0, 1'b0, rd);
        chk("lb_0x41", rd, 32'hFFFFFFAA);
        do_txn(1'b0, 2'd0, 1'b1, 32'h41, 32'd0, 0, 1'b0, rd);
        chk("lbu_0x41", rd, 32'h000000AA);
        do_txn(1'b1, 2'd1, 1'b0, 32'h42, 32'h00001234, 0, 1'b0, rd);
        do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, 1'b0, rd);
        chk("lw_after_sh", rd, 32'h1234AABB);
        do_txn(1'b1, 2'd2, 1'b0, 32'h80, 32'hDEADBEEF, 0, 1'b0, rd);
        chk("sw_rdata_zero", rd, 32'd0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h82, 32'd0, 0, 1'b0, rd);
        do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 5, 1'b1, rd);
        do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 0, 1'b0, rd);
        chk("poke_ignored", rd, 32'h1234AABB);

        // Reset during the WRITE cycle of a byte store.
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'd0; REQ_ADDR = 32'h45; REQ_WDATA = 32'h77;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("rst_mid_we_before", 32'(MEM_WE), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("rst_mid_we_low", 32'(MEM_WE), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        chk("rst_mid_req_ready", 32'(REQ_READY), 32'd1);
        chk("rst_mid_mem_word", mem[17], ref_mem[17]);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("rst_mid_no_rsp", 32'(RSP_VALID), 32'd0);
        end

        for (int n = 0; n < 150; n++) begin
            do_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                   32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 3), 1'b0, rd);
        end
        for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store unit that sits between the core's execute stage and the word-only data memory, acting as the initiator on the memory's word interface. Accepts byte, halfword and word load/store requests over a valid/ready handshake, performs read-modify-write for sub-word stores because the memory has no byte enables, and extracts and extends sub-word load data. It returns one response per request and detects misaligned accesses.

## Interface
- No parameters. The data width is fixed at 32 and the address width at 32.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `REQ_VALID` in 1: the core presents a request.
- `REQ_READY` out 1: the LSU can accept a request. High only in IDLE.
- `REQ_WE` in 1: 1 = store, 0 = load.
- `REQ_SIZE` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `REQ_UNSIGNED` in 1: zero-extend load data (LBU/LHU). Ignored for stores.
- `REQ_ADDR` in 32: byte address.
- `REQ_WDATA` in 32: store data, right-justified.
- `RSP_VALID` out 1: response available; held until `RSP_READY`.
- `RSP_READY` in 1: the core accepts the response.
- `RSP_RDATA` out 32: load result. 0 for stores and errors.
- `RSP_ERR` out 1: misaligned access. Only driven when the feature is compiled in.
- `MEM_WE` out 1: memory write strobe.
- `MEM_A` out 32: word-aligned byte address to memory, with bits [1:0] = 00.
- `MEM_WD` out 32: full-word write data.
- `MEM_RD` in 32: combinational memory read data for the address on `MEM_A`.

## Operation
- **State machine:** IDLE, READ, WRITE, RESP.
- **IDLE:** `REQ_READY`=1. On `REQ_VALID`, latch WE, SIZE, UNSIGNED, ADDR and WDATA, then go to the next state:
  - misaligned request with the feature compiled in: RESP with err=1;
  - word store: WRITE;
  - any other request: READ.
- **READ:** drive `MEM_A` = {addr[31:2],2'b00} and capture `MEM_RD` into the data register.
  - Load: compute the result and go to RESP.
  - Sub-word store: merge the new data into the captured word and go to WRITE.
- **WRITE:** `MEM_WE`=1 for exactly this cycle, with `MEM_WD` = merged word (or the full WDATA for a word store). Then go to RESP.
- **RESP:** `RSP_VALID`=1. On `RSP_READY`, go to IDLE. `RSP_RDATA` and `RSP_ERR` are stable for the whole RESP state.
- **Lanes are little-endian:**
  - a byte uses lane addr[1:0];
  - a half uses bytes {addr[1],0} and {addr[1],1}.
- **Load extension:** sign-extend from bit 7 (byte) or bit 15 (half) unless UNSIGNED is set. A word load passes through unchanged.
- **Store merge:** only the addressed lane(s) are replaced; all other bytes keep the value read in READ.
- **Misaligned:** a half with addr[0]=1, or a word with addr[1:0]≠00. A byte access is never misaligned.
- **Error response:** no memory access occurs and `MEM_WE` stays 0.

## Timing
- **Reset values:** state IDLE, `REQ_READY`=1 after reset, and `RSP_VALID`, `RSP_RDATA`, `RSP_ERR`, `MEM_WE`, `MEM_A` and `MEM_WD` all = 0.
- **Reset mid-operation:** `RST_N` low in any state returns to IDLE on the next edge. `MEM_WE` is low in that same cycle, and the pending request is dropped with no response.
- **Latency,** counting the handshake edge as cycle 0, to the first `RSP_VALID` cycle:
  - word load: 2;
  - word store: 2;
  - sub-word load: 2;
  - sub-word store: 3;
  - misaligned error: 1.
- **Memory write timing:** the write lands at the rising edge that ends the WRITE cycle, so the memory already holds the new data when RSP_VALID rises.
- **Back-to-back requests:** not overlapped. A new request is accepted only in IDLE, at the earliest the cycle after the `RSP_READY` handshake.
- **Request inputs:** `REQ_*` is ignored outside IDLE.
- **`MEM_A`:** holds the latched aligned address from READ onward until the next accept. It is never X.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - misaligned accesses go IDLE→RESP with `RSP_ERR`=1 and `RSP_RDATA`=0;
  - memory is untouched.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `RSP_ERR` is tied to 0;
  - the address is silently aligned down to its size (half clears addr[0], word clears addr[1:0]);
  - the access then proceeds normally.

## Test plan
- Memory word 0x40 preloaded with 0x8899AABB. LB at 0x41 → `RSP_RDATA`=0xFFFFFFAA at cycle 2. LBU at 0x41 → 0x000000AA.
- Memory word 0x40 preloaded with 0x8899AABB. SH 0x1234 at 0x42 → READ then exactly one `MEM_WE` pulse with `MEM_WD`=0x1234AABB. `RSP_VALID` at cycle 3, and a following LW 0x40 → 0x1234AABB.
- SW 0xDEADBEEF at 0x80 → no READ state. `MEM_WE` in cycle 1 with `MEM_A`=0x80. `RSP_VALID` in cycle 2 with `RSP_RDATA`=0.
- LW at 0x82:
  - with the macro: `RSP_ERR`=1 at cycle 1 and no memory access;
  - without the macro: returns the word at 0x80 with `RSP_ERR`=0.
- `RSP_READY` held low for 5 cycles → `RSP_VALID` and the data stay stable and `REQ_READY` stays 0. A `REQ_VALID` pulse during the stall is ignored.
- `RST_N` low during the WRITE cycle of an SB → `MEM_WE`=0 that cycle and the memory is unchanged. IDLE with `REQ_READY`=1 after `RST_N` releases, and no response is issued.
